// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, fetch FSM state type and opcode field bounds
package cpu_pkg;

    localparam int ADDR_W  = 28;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_HOLD = 2'd2,
        IFU_HALT = 2'd3
    } ifu_state_t;

    // Opcode field position inside an instruction word, shared with instruction_register
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

endpackage

// File: rtl/ifu_pc_reg.sv
// rtl/ifu_pc_reg.sv - program counter register with reset / jump / increment / hold select
module ifu_pc_reg
    import cpu_pkg::*;
#(
    parameter int              PC_W     = ADDR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic [PC_W-1:0] load_value,
    input  logic            advance,
    output logic [PC_W-1:0] pc
);

    // Increment deliberately truncates so the PC wraps to zero at the top of memory
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (advance) begin
            pc <= pc + PC_W'(PC_STEP);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, word fetch FSM and IR-facing output registers; optional watchdog via IFU_TIMEOUT_EN
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W         = cpu_pkg::ADDR_W,
    parameter int                INSTR_W        = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0,
    parameter int                PC_STEP        = 4,
    parameter int                TIMEOUT_CYCLES = 16
) (
    input  logic               clock,
    input  logic               reset,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ready,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               jump_valid,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic               stall,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out
`ifdef IFU_TIMEOUT_EN
    ,
    output logic               fetch_fault
`endif
);

    localparam logic [1:0] ST_IDLE = 2'(IFU_IDLE);
    localparam logic [1:0] ST_REQ  = 2'(IFU_REQ);
    localparam logic [1:0] ST_HOLD = 2'(IFU_HOLD);
    localparam logic [1:0] ST_HALT = 2'(IFU_HALT);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic              jump_take;
    logic              capture;

    // A jump wins over any returned data; a halted unit ignores jumps
    assign jump_take = jump_valid && (state != ST_HALT);
    assign capture   = (state == ST_REQ) && mem_ready && !jump_valid;

    assign mem_req  = (state == ST_REQ);
    assign mem_addr = pc;

    ifu_pc_reg #(
        .PC_W     (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clock      (clock),
        .reset      (reset),
        .load       (jump_take),
        .load_value (jump_target),
        .advance    (capture),
        .pc         (pc)
    );

`ifdef IFU_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            pc_out      <= '0;
            wd_count    <= '0;
            fetch_fault <= 1'b0;
        end else if (state == ST_HALT) begin
            state <= ST_HALT;
        end else if (jump_valid) begin
            state       <= ST_REQ;
            instr_valid <= 1'b0;
            wd_count    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_REQ;
                    wd_count <= '0;
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        instr_out   <= mem_rdata;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        state       <= ST_HOLD;
                    end else if (wd_count == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        fetch_fault <= 1'b1;
                        state       <= ST_HALT;
                    end else begin
                        wd_count <= wd_count + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        state       <= ST_REQ;
                        wd_count    <= '0;
                    end
                end
                default: state <= ST_HALT;
            endcase
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES[0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            pc_out      <= '0;
        end else if (jump_take) begin
            state       <= ST_REQ;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_REQ;
                ST_REQ: begin
                    if (mem_ready) begin
                        instr_out   <= mem_rdata;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        state       <= ST_REQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized bench for instruction_fetch_unit against a behavioural fetch model
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [27:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        jump_valid = 1'b0;
    logic [27:0] jump_target = '0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [27:0] pc_out;
`ifdef IFU_TIMEOUT_EN
    logic        fetch_fault;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: pc, whether a word is held for the IR, and whether the post-reset idle cycle has passed
    logic [27:0] m_pc;
    logic        m_held;
    logic        m_started;
    logic [31:0] m_instr;
    logic [27:0] m_pcout;
    logic        m_halted;
    int          m_wait;

    always #5 clock = ~clock;

    instruction_fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .pc_out      (pc_out)
`ifdef IFU_TIMEOUT_EN
        ,
        .fetch_fault (fetch_fault)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_held = 0; m_started = 0; m_instr = '0; m_pcout = '0;
        m_halted = 0; m_wait = 0;
    endtask

    task automatic compare_all();
        check("mem_req", 32'(mem_req), 32'(m_started && !m_held && !m_halted));
        check("mem_addr", 32'(mem_addr), 32'(m_pc));
        check("instr_valid", 32'(instr_valid), 32'(m_held));
        check("instr_out", instr_out, m_instr);
        check("pc_out", 32'(pc_out), 32'(m_pcout));
`ifdef IFU_TIMEOUT_EN
        check("fetch_fault", 32'(fetch_fault), 32'(m_halted));
`endif
    endtask

    // One clock: drive, compare at the falling edge, step the model on the rising edge
    task automatic cycle(input logic r, input logic rdy, input logic [31:0] rd,
                         input logic jv, input logic [27:0] jt, input logic st);
        reset = r; mem_ready = rdy; mem_rdata = rd;
        jump_valid = jv; jump_target = jt; stall = st;
        @(negedge clock);
        compare_all();
        @(posedge clock);
        if (r) begin
            model_reset();
        end else if (m_halted) begin
            m_halted = 1;
        end else if (jv) begin
            m_pc = jt; m_held = 0; m_started = 1; m_wait = 0;
        end else if (!m_started) begin
            m_started = 1; m_wait = 0;
        end else if (m_held) begin
            if (!st) begin
                m_held = 0; m_wait = 0;
            end
        end else if (rdy) begin
            m_instr = rd; m_pcout = m_pc; m_pc = m_pc + 28'd4; m_held = 1;
        end else begin
            m_wait++;
`ifdef IFU_TIMEOUT_EN
            if (m_wait == 16) m_halted = 1;
`endif
        end
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;

        // Reset state and first-fetch latency with mem_ready tied high
        cycle(1, 1, 32'hA000_0010, 0, '0, 0);
        cycle(1, 1, 32'hA000_0010, 0, '0, 0);
        cycle(0, 1, 32'hA000_0010, 0, '0, 0);
        check("t1_idle_valid", 32'(instr_valid), 32'd0);
        check("t1_req_addr", 32'(mem_addr), 32'h0);
        cycle(0, 1, 32'hA000_0010, 0, '0, 0);
        check("t1_first_valid", 32'(instr_valid), 32'd1);
        check("t1_first_instr", instr_out, 32'hA000_0010);
        check("t1_first_pc", 32'(pc_out), 32'h0);
        check("t1_next_addr", 32'(mem_addr), 32'h4);

        // Stall held for five cycles in HOLD
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 32'h1234_5678, 0, '0, 1);
            check("t2_stall_req", 32'(mem_req), 32'd0);
            check("t2_stall_instr", instr_out, 32'hA000_0010);
        end
        cycle(0, 1, 32'h1234_5678, 0, '0, 0);
        check("t2_resume_req", 32'(mem_req), 32'd1);

        // Capture, then jump while holding
        cycle(0, 1, 32'h1111_2222, 0, '0, 1);
        cycle(0, 0, 32'h0, 1, 28'h0000100, 1);
        check("t3_jump_drop", 32'(instr_valid), 32'd0);
        check("t3_jump_addr", 32'(mem_addr), 32'h100);
        cycle(0, 1, 32'h3333_4444, 0, '0, 1);
        check("t3_jump_pcout", 32'(pc_out), 32'h100);

        // Jump coinciding with returned data in REQ
        cycle(0, 0, 32'h0, 0, '0, 0);
        cycle(0, 1, 32'hDEAD_BEEF, 1, 28'h0000A40, 0);
        check("t4_dropped", 32'(instr_valid), 32'd0);
        check("t4_addr", 32'(mem_addr), 32'hA40);

        // Wrap past the top of the address space
        cycle(0, 0, 32'h0, 1, 28'hFFFFFFC, 0);
        cycle(0, 1, 32'h5555_AAAA, 0, '0, 0);
        check("t5_wrap_pcout", 32'(pc_out), 32'hFFFFFFC);
        check("t5_wrap_addr", 32'(mem_addr), 32'h0);

        // Reset arriving in REQ with data ready
        cycle(0, 0, 32'h0, 0, '0, 0);
        check("t6_in_req", 32'(mem_req), 32'd1);
        cycle(1, 1, 32'h7777_7777, 0, '0, 0);
        check("t6_rst_valid", 32'(instr_valid), 32'd0);
        check("t6_rst_instr", instr_out, 32'h0);
        check("t6_rst_addr", 32'(mem_addr), 32'h0);
        cycle(0, 0, 32'h0, 0, '0, 0);

`ifdef IFU_TIMEOUT_EN
        cycle(0, 0, 32'h0, 0, '0, 0);
        for (int i = 0; i < 16; i++) cycle(0, 0, 32'h0, 0, '0, 0);
        check("t6_fault", 32'(fetch_fault), 32'd1);
        check("t6_fault_req", 32'(mem_req), 32'd0);
        cycle(0, 1, 32'h0, 1, 28'h0000200, 0);
        check("t6_halt_jump", 32'(mem_addr), 32'(m_pc));
        check("t6_halt_sticky", 32'(fetch_fault), 32'd1);
        cycle(1, 0, 32'h0, 0, '0, 0);
        check("t6_fault_clear", 32'(fetch_fault), 32'd0);
        cycle(0, 0, 32'h0, 0, '0, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 1) == 1),
                  $urandom(),
                  ($urandom_range(0, 15) == 0),
                  (($urandom_range(0, 3) == 0) ? 28'hFFFFFF8 + 28'($urandom_range(0, 7)) : 28'($urandom())),
                  ($urandom_range(0, 9) < 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
